// File: rtl/uart_transmitter.sv
// Byte FIFO with registered full/empty flags; full is judged before any same-edge pop.
// Latency: a written byte is visible at the head (empty=0) on the edge after the write.
// Backpressure: writes while full are dropped; pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, storage and flags; flags are registered from the next count.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end
endmodule

// UART transmitter: FIFO-fed 8N1/8N2 serialiser, 16 clken ticks per bit cell, LSB first.
// Latency: start bit begins on the first clken edge after the byte becomes visible in the FIFO.
// Backpressure: host watches full; a write while full is dropped. Frames run back-to-back.
module uart_transmitter #(
  parameter int DEPTH       = 4,
  parameter int STOP_BITS   = 1,
  parameter int INVERT_DATA = 1
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clken,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       Tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_t     state, state_nxt;
  logic [3:0] tick, tick_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic       stop_idx, stop_idx_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       tx_nxt;
  logic       pop;
  logic [7:0] head;
  logic [7:0] head_line;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk_50m (clk_50m),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // The receiver complements captured bits, so the line carries the inverse when enabled.
  assign head_line = (INVERT_DATA != 0) ? ~head : head;
  assign busy      = (state != IDLE);

  // Frame sequencing; nothing moves except on clken.
  always_comb begin
    state_nxt    = state;
    tick_nxt     = tick;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    shreg_nxt    = shreg;
    tx_nxt       = Tx;
    pop          = 1'b0;
    if (clken) begin
      case (state)
        IDLE: begin
          tx_nxt = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            shreg_nxt = head_line;
            tx_nxt    = 1'b0;
            tick_nxt  = 4'd0;
            state_nxt = START;
          end
        end
        START: begin
          tick_nxt = tick + 4'd1;
          if (tick == 4'd15) begin
            tick_nxt    = 4'd0;
            bit_idx_nxt = 3'd0;
            tx_nxt      = shreg[0];
            state_nxt   = DATA;
          end
        end
        DATA: begin
          tick_nxt = tick + 4'd1;
          if (tick == 4'd15) begin
            if (bit_idx < 3'd7) begin
              // Shift so the next bit to send always sits at position 1.
              bit_idx_nxt = bit_idx + 3'd1;
              tx_nxt      = shreg[1];
              shreg_nxt   = {1'b0, shreg[7:1]};
            end else begin
              tx_nxt       = 1'b1;
              tick_nxt     = 4'd0;
              stop_idx_nxt = 1'b0;
              state_nxt    = STOP;
            end
          end
        end
        STOP: begin
          tick_nxt = tick + 4'd1;
          if (tick == 4'd15) begin
            tick_nxt = 4'd0;
            if (stop_idx == LAST_STOP) begin
              if (!empty) begin
                // Chain straight into the next start bit with no idle gap.
                pop       = 1'b1;
                shreg_nxt = head_line;
                tx_nxt    = 1'b0;
                state_nxt = START;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              stop_idx_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and line registers; reset aborts any frame in flight.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= 4'd0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      shreg    <= 8'd0;
      Tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      tick     <= tick_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      shreg    <= shreg_nxt;
      Tx       <= tx_nxt;
    end
  end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART transmit side for the serial link; the counterpart of the existing UART receiver block.
- Accepts bytes from the host through a small FIFO and serialises each one as 8N1 (optionally 8N2) frames on Tx.
- Timing comes from the shared 16x-oversample clken strobe, the same one the receiver consumes. One bit cell is exactly 16 clken ticks.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of 2, range 2..16.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- INVERT_DATA, 1, when 1 the data bits on the line are the complement of the written byte. Our receiver complements captured bits, so 1 makes a loopback return the original byte. When 0, bits are sent as written.

Ports:
- clk_50m  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- clken  in  1  16x baud strobe, one clk_50m cycle wide.
- data_in  in  8  byte to transmit.
- wr_en  in  1  write data_in into the FIFO.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  a frame is in progress (state != IDLE).
- Tx  out  1  serial line, idle high, registered output.

Behaviour:
- Reset (rst=1 at an edge) wins over everything else. Registered values: Tx=1, busy=0, full=0, empty=1. FIFO pointers and count cleared, state=IDLE, tick=0, bit index=0.
- Reset mid-frame aborts the frame: Tx is 1 after that edge, and no partial byte is resumed.
- FIFO write: on any edge with wr_en=1 and full=0, data_in is stored at the tail and count increments.
  - full and empty are registered from count.
  - wr_en while full=1 drops the byte; no state change. full is judged before any same-cycle pop, so a write while full is dropped even if a pop occurs that edge.
  - A simultaneous write and pop with full=0 leaves count unchanged.
- Written data is eligible for pop no earlier than the edge after the write.
- State machine states: IDLE, START, DATA, STOP. A 4-bit tick counter and a 3-bit bit index are used. All advancement happens only on edges with clken=1; with clken=0 every register except the FIFO write side holds.
- IDLE:
  - Tx=1, busy=0.
  - On clken with empty=0: pop head into the shift register (complemented if INVERT_DATA=1), Tx<=0, tick<=0, state<=START, busy<=1.
- START: on clken, tick increments. At tick==15: tick<=0, bit index<=0, Tx<=shift bit 0, state<=DATA.
- DATA:
  - On clken, tick increments.
  - At tick==15: if bit index<7, bit index increments and Tx<=next bit (LSB first).
  - At tick==15 with bit index==7: Tx<=1, state<=STOP, tick<=0.
- STOP:
  - Tx=1 for 16*STOP_BITS ticks; the stop-bit counter sits alongside tick.
  - On the clken that ends the last stop tick: if empty=0, pop immediately and enter START with Tx<=0. There is no idle gap, so back-to-back frames are contiguous.
  - Otherwise, if empty=1 at that clken, go to IDLE with busy<=0.
- Frame length: (10 + STOP_BITS - 1) * 16 clken ticks. Tx changes only on clken edges, so it is glitch-free and registered.
- Latency: the first start-bit edge appears on the first clken edge strictly after the write edge.

Test Plan:
- INVERT_DATA=0, write 0xA5, clken every 4th cycle:
  - Tx holds each value for 16 ticks in this order: 0, 1,0,1,0,0,1,0,1, 1.
  - busy drops after 160 ticks and empty=1.
- INVERT_DATA=1, write 0x3C, Tx looped into the receiver block: line data bits are 1,1,0,0,0,0,1,1; receiver presents data=0x3C with ready=1.
- Hold clken=0 and write 5 bytes 0x01..0x05:
  - full=1 after the 4th write; the 5th is dropped.
  - Release clken: 4 contiguous frames (640 ticks) carrying 0x01..0x04, no Tx high gap beyond the stop bits; then IDLE, empty=1.
- Reset mid-frame: assert rst at tick 5 of data bit 3.
  - Next edge: Tx=1, busy=0, empty=1.
  - A subsequent write of 0x55 transmits a clean full frame.
- Full-boundary write: with the FIFO full, set wr_en=1 on the same edge as the pop at the end of a STOP. The byte is dropped, full goes to 0 after that edge, and the next wr_en is accepted.
- clken gaps: random clken spacing of 1..20 cycles. Each bit cell is still exactly 16 clken strobes, and Tx never changes on a non-clken edge.
